// File: rtl/rf_control_unit.sv
// Multi-cycle controller for the 16-register datapath: holds PC and IR, fetches
// instructions and sequences register file, data memory and ALU.
module rf_control_unit #(
    parameter int PCW = 7,
    parameter int DAW = 8,
    parameter int RAW = 4
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic [15:0]    Instr,
    output logic [PCW-1:0] PC_Addr,
    output logic [15:0]    IR,
    output logic [DAW-1:0] D_Addr,
    output logic           D_Wr,
    output logic           RF_s,
    output logic [RAW-1:0] RF_W_Addr,
    output logic           RF_W_en,
    output logic [RAW-1:0] RF_Ra_Addr,
    output logic [RAW-1:0] RF_Rb_Addr,
    output logic [2:0]     Alu_s0,
    output logic           Halted,
    output logic [3:0]     State
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD_A = 4'd3,
        S_LOAD_B = 4'd4,
        S_STORE  = 4'd5,
        S_ADD    = 4'd6,
        S_SUB    = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    typedef struct packed {
        logic [DAW-1:0] d_addr;
        logic           d_wr;
        logic           rf_s;
        logic [RAW-1:0] w_addr;
        logic           w_en;
        logic [RAW-1:0] ra_addr;
        logic [RAW-1:0] rb_addr;
        logic [2:0]     alu_s0;
        logic           halted;
    } ctrl_t;

    state_t         state_reg, state_next;
    logic [PCW-1:0] pc_reg, pc_next;
    logic [15:0]    ir_reg, ir_next;
    ctrl_t          ctrl_reg;

    // Datapath controls as a pure function of (state, IR); the register stage
    // below evaluates it on the next state so the outputs line up with State.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [15:0] ir);
        ctrl_t c;
        c = '0;
        case (s)
            S_STORE: begin
                c.d_addr  = ir[4 +: DAW];
                c.ra_addr = ir[0 +: RAW];
                c.d_wr    = 1'b1;
            end
            S_LOAD_A: begin
                c.d_addr = ir[4 +: DAW];
                c.rf_s   = 1'b1;
            end
            S_LOAD_B: begin
                c.d_addr = ir[4 +: DAW];
                c.rf_s   = 1'b1;
                c.w_addr = ir[0 +: RAW];
                c.w_en   = 1'b1;
            end
            S_ADD, S_SUB: begin
                c.ra_addr = ir[8 +: RAW];
                c.rb_addr = ir[4 +: RAW];
                c.w_addr  = ir[0 +: RAW];
                c.w_en    = 1'b1;
                c.alu_s0  = (s == S_ADD) ? 3'd1 : 3'd2;
            end
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        case (state_reg)
            S_INIT:  state_next = S_FETCH;
            S_FETCH: begin
                ir_next    = Instr;
                pc_next    = pc_reg + PCW'(1);
                state_next = S_DECODE;
            end
            S_DECODE: begin
                case (ir_reg[15:12])
                    4'd1:    state_next = S_STORE;
                    4'd2:    state_next = S_LOAD_A;
                    4'd3:    state_next = S_ADD;
                    4'd4:    state_next = S_SUB;
                    4'd5:    state_next = S_HALT;
                    default: state_next = S_FETCH;
                endcase
            end
            S_LOAD_A: state_next = S_LOAD_B;
            S_LOAD_B, S_STORE, S_ADD, S_SUB: state_next = S_FETCH;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg <= S_INIT;
            pc_reg    <= '0;
            ir_reg    <= '0;
            ctrl_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            ctrl_reg  <= decode_ctrl(state_next, ir_next);
        end
    end

    assign PC_Addr    = pc_reg;
    assign IR         = ir_reg;
    assign State      = state_reg;
    assign D_Addr     = ctrl_reg.d_addr;
    assign D_Wr       = ctrl_reg.d_wr;
    assign RF_s       = ctrl_reg.rf_s;
    assign RF_W_Addr  = ctrl_reg.w_addr;
    assign RF_W_en    = ctrl_reg.w_en;
    assign RF_Ra_Addr = ctrl_reg.ra_addr;
    assign RF_Rb_Addr = ctrl_reg.rb_addr;
    assign Alu_s0     = ctrl_reg.alu_s0;
    assign Halted     = ctrl_reg.halted;

endmodule

// File: tb/tb_rf_control_unit.sv
// Directed bench for rf_control_unit: a small instruction ROM feeds Instr and
// each step checks state, PC/IR and the control strobes against hand values.
module tb_rf_control_unit;

    logic        Clk;
    logic        Rst;
    logic [15:0] Instr;
    logic [6:0]  PC_Addr;
    logic [15:0] IR;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic [3:0]  RF_W_Addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic [2:0]  Alu_s0;
    logic        Halted;
    logic [3:0]  State;

    logic [15:0] imem [0:127];
    int          n_asserts;
    int          n_fail;
    logic        noop_strobe;

    rf_control_unit dut (
        .Clk(Clk), .Rst(Rst), .Instr(Instr), .PC_Addr(PC_Addr), .IR(IR),
        .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_Addr(RF_W_Addr),
        .RF_W_en(RF_W_en), .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr),
        .Alu_s0(Alu_s0), .Halted(Halted), .State(State)
    );

    assign Instr = imem[PC_Addr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {D_Wr, RF_W_en, RF_s, Alu_s0, Halted}
    function automatic logic [15:0] strobes();
        return {9'd0, D_Wr, RF_W_en, RF_s, Alu_s0, Halted};
    endfunction

    function automatic logic [15:0] addrs();
        return {RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, 4'd0} | {8'd0, D_Addr};
    endfunction

    initial begin
        n_asserts   = 0;
        n_fail      = 0;
        noop_strobe = 1'b0;
        for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
        imem[0] = 16'h3123;
        imem[1] = 16'h21A5;
        imem[2] = 16'h1FF7;
        imem[3] = 16'hE000;
        imem[4] = 16'h0000;

        // Reset held two cycles
        Rst = 1'b1;
        step();
        step();
        check("rst_state", {12'd0, State}, 16'd0);
        check("rst_pc", {9'd0, PC_Addr}, 16'd0);
        check("rst_ir", IR, 16'h0000);
        check("rst_strobes", strobes(), 16'd0);
        check("rst_addrs", addrs(), 16'd0);
        Rst = 1'b0;
        step();
        check("init_to_fetch", {12'd0, State}, 16'd1);
        check("fetch_pc", {9'd0, PC_Addr}, 16'd0);
        check("fetch_strobes", strobes(), 16'd0);
        step();
        check("add_decode_state", {12'd0, State}, 16'd2);
        check("add_ir", IR, 16'h3123);
        check("add_pc", {9'd0, PC_Addr}, 16'd1);
        check("decode_strobes", strobes(), 16'd0);
        $display("reset then fetch of 3123: state=%0d pc=%0d ir=%h", State, PC_Addr, IR);

        // ADD r1+r2 -> r3
        step();
        check("add_state", {12'd0, State}, 16'd6);
        check("add_ra", {12'd0, RF_Ra_Addr}, 16'd1);
        check("add_rb", {12'd0, RF_Rb_Addr}, 16'd2);
        check("add_wa", {12'd0, RF_W_Addr}, 16'd3);
        check("add_strobes", strobes(), {9'd0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0});
        step();
        check("add_back_fetch", {12'd0, State}, 16'd1);
        check("add_one_cycle", strobes(), 16'd0);
        $display("ADD 3123 done: state=%0d pc=%0d", State, PC_Addr);

        // LOAD 21A5
        step();
        check("load_ir", IR, 16'h21A5);
        check("load_pc", {9'd0, PC_Addr}, 16'd2);
        step();
        check("loada_state", {12'd0, State}, 16'd3);
        check("loada_daddr", {8'd0, D_Addr}, 16'h001A);
        check("loada_strobes", strobes(), {9'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0});
        step();
        check("loadb_state", {12'd0, State}, 16'd4);
        check("loadb_daddr", {8'd0, D_Addr}, 16'h001A);
        check("loadb_wa", {12'd0, RF_W_Addr}, 16'd5);
        check("loadb_strobes", strobes(), {9'd0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0});
        step();
        check("load_back_fetch", {12'd0, State}, 16'd1);
        $display("LOAD 21A5 done: state=%0d pc=%0d", State, PC_Addr);

        // STORE 1FF7
        step();
        check("store_ir", IR, 16'h1FF7);
        step();
        check("store_state", {12'd0, State}, 16'd5);
        check("store_daddr", {8'd0, D_Addr}, 16'h00FF);
        check("store_ra", {12'd0, RF_Ra_Addr}, 16'd7);
        check("store_strobes", strobes(), {9'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0});
        step();
        check("store_back_fetch", {12'd0, State}, 16'd1);
        check("store_pc", {9'd0, PC_Addr}, 16'd3);
        $display("STORE 1FF7 done: state=%0d pc=%0d", State, PC_Addr);

        // Illegal opcode E000 then NOOP
        step();
        check("ill_decode", {12'd0, State}, 16'd2);
        check("ill_pc", {9'd0, PC_Addr}, 16'd4);
        check("ill_strobes", strobes(), 16'd0);
        step();
        check("ill_to_fetch", {12'd0, State}, 16'd1);
        check("ill_fetch_strobes", strobes(), 16'd0);
        step();
        check("noop_decode", {12'd0, State}, 16'd2);
        check("noop_pc", {9'd0, PC_Addr}, 16'd5);
        step();
        check("noop_to_fetch", {12'd0, State}, 16'd1);
        $display("E000 and 0000 done: state=%0d pc=%0d", State, PC_Addr);

        // NOOP run up to PC 127, bounded
        for (int i = 0; i < 400 && !(State == 4'd1 && PC_Addr == 7'd127); i++) begin
            step();
            if (D_Wr || RF_W_en) noop_strobe = 1'b1;
        end
        check("wrap_reach_state", {12'd0, State}, 16'd1);
        check("wrap_reach_pc", {9'd0, PC_Addr}, 16'd127);
        check("noop_run_strobes", {15'd0, noop_strobe}, 16'd0);
        step();
        check("wrap_pc", {9'd0, PC_Addr}, 16'd0);
        $display("PC wrap: state=%0d pc=%0d", State, PC_Addr);

        // HALT from address 0
        imem[0] = 16'h5000;
        step();
        step();
        check("halt_ir", IR, 16'h5000);
        for (int i = 0; i < 6; i++) begin
            step();
            check("halt_state", {12'd0, State}, 16'd8);
            check("halt_strobes", strobes(), 16'd1);
            check("halt_pc", {9'd0, PC_Addr}, 16'd1);
        end
        $display("HALT: state=%0d halted=%0b pc=%0d", State, Halted, PC_Addr);
        Rst = 1'b1;
        step();
        check("halt_rst_state", {12'd0, State}, 16'd0);
        check("halt_rst_pc", {9'd0, PC_Addr}, 16'd0);
        check("halt_rst_strobes", strobes(), 16'd0);
        check("halt_rst_ir", IR, 16'h0000);
        $display("reset from HALT: state=%0d halted=%0b", State, Halted);

        // SUB abandoned by reset
        imem[0] = 16'h4456;
        Rst = 1'b0;
        step();
        step();
        check("sub_ir", IR, 16'h4456);
        step();
        check("sub_state", {12'd0, State}, 16'd7);
        check("sub_addrs", {RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, 4'd0}, 16'h4560);
        check("sub_strobes", strobes(), {9'd0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0});
        Rst = 1'b1;
        step();
        check("sub_rst_state", {12'd0, State}, 16'd0);
        check("sub_rst_strobes", strobes(), 16'd0);
        $display("reset during SUB: state=%0d wen=%0b alu=%0d", State, RF_W_en, Alu_s0);
        Rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
